mem_word_ctrl: RTL
==================

// Module: mem_word_ctrl
// PURPOSE
//   Initiator-side controller for the 256 x 8-bit synchronous byte memory.
//   Turns single 32-bit CPU load/store requests into sequences of byte
//   accesses on the memory port. Stores are split into 4 byte writes; loads
//   are assembled from 4 pipelined byte reads. Word layout is big-endian.
//   Sits between the CPU datapath (fetch and load/store unit) and the memory.
// PARAMETERS
//   ADDR_W   8    byte address width; addresses wrap modulo 2**ADDR_W
//   BYTE_W   8    memory data width
//   NBYTES   4    bytes per word; the word is NBYTES*BYTE_W bits
// PORTS
//   clk           in   1   single clock, rising edge
//   reset         in   1   asynchronous, active-high
//   req_valid     in   1   request present
//   req_ready     out  1   controller idle, can accept a request
//   req_write     in   1   1 = store, 0 = load
//   req_addr      in   8   base byte address
//   req_wdata     in   32  store data; bits [31:24] go to base
//   rsp_valid     out  1   one-cycle pulse: access complete
//   rsp_rdata     out  32  load data, valid while rsp_valid is high
//   rsp_err       out  1   misaligned request flagged (see CONFIGURATION)
//   mem_memwrite  out  1   memory write enable
//   mem_addr      out  8   memory address
//   mem_data_in   out  8   memory write data
//   mem_data_out  in   8   memory read data; 1-edge registered latency
// BEHAVIOUR
//   - All outputs are registered. Reset forces req_ready=1 and all other
//     outputs to 0. The FSM goes to IDLE and the byte counter to 0.
//   - Accept: a request is taken on an edge where req_valid & req_ready.
//     req_ready=1 only in IDLE. Request fields are latched on that edge (E0).
//   - States: IDLE -> WR (4 cycles) -> IDLE; IDLE -> RD (4 issue cycles)
//     -> RD_TAIL (1 cycle) -> IDLE.
//   - WR: at edges E0..E3, drive mem_addr=base+i, mem_data_in=byte i
//     (byte 0 = wdata[31:24]), and mem_memwrite=1.
//     At E4: mem_memwrite=0, rsp_valid=1, back to IDLE.
//     mem_memwrite is high for exactly 4 cycles.
//   - RD: at E0..E3, drive mem_addr=base+i with mem_memwrite=0.
//     Byte i is captured from mem_data_out at edge E(i+2) into rsp_rdata
//     (byte 0 goes to [31:24]). At E5: rsp_valid=1, back to IDLE.
//   - Latency from accept edge to rsp_valid: load 5 edges, store 4 edges.
//   - Back-to-back: a new request can be accepted on the cycle rsp_valid
//     is high, because the state is already IDLE.
//   - Address arithmetic: base+i is computed mod 256, so 0xFE reads
//     0xFE, 0xFF, 0x00, 0x01.
//   - rsp_rdata holds its value until the next load completes. Stores leave
//     it unchanged.
//   - rsp_valid and rsp_err are single-cycle pulses. There is no backpressure
//     on the response.
//   - Reset mid-operation: mem_memwrite drops asynchronously and no
//     rsp_valid is produced. Bytes already written stay written; the rest are
//     untouched.
//   - req_valid while busy is ignored. The requester must hold it until
//     accepted.
// CONFIGURATION
//   MEM_ALIGN_CHECK_EN defined:
//     - A request with req_addr[1:0]!=0 is accepted and performs no memory
//       access (mem_memwrite stays 0).
//     - At E1: rsp_valid=1, rsp_err=1, rsp_rdata=0, back to IDLE.
//   MEM_ALIGN_CHECK_EN undefined:
//     - Unaligned addresses are serviced normally, with wrap-around.
//     - rsp_err is tied to 0.
// STRUCTURE
//   - Package mem_ctrl_pkg holds: FSM state encoding (IDLE, WR, RD, RD_TAIL),
//     NBYTES, and the WORD_W = NBYTES*BYTE_W constant.
//   - No sub-module. The FSM, the 2-bit byte counter and the shift-in
//     assembler are inline.
// TESTING
//   1. Preload mem[0x10..0x13]=12,34,56,78; load 0x10
//      -> rsp_valid 5 edges after accept, rsp_rdata=0x12345678.
//   2. Store 0xDEADBEEF @0x20 -> mem_memwrite high exactly 4 cycles;
//      mem[0x20..0x23]=DE,AD,BE,EF; rsp_valid at E4; mem[0x1F], mem[0x24]
//      unchanged.
//   3. Wrap: preload FE,FF,00,01 = AA,BB,CC,DD; load 0xFE (macro off)
//      -> rsp_rdata=0xAABBCCDD.
//   4. Back-to-back: store 0xCAFEF00D @0x40, load 0x40 presented during the
//      rsp cycle -> accepted that edge; rsp_rdata=0xCAFEF00D with no idle gap.
//   5. Assert reset two cycles into a store @0x50 (mem pre-cleared)
//      -> mem_memwrite=0 immediately, req_ready=1, no rsp_valid;
//      only mem[0x50..0x51] modified.
//   6. MEM_ALIGN_CHECK_EN defined: load 0x21 -> rsp_valid & rsp_err at E1,
//      rsp_rdata=0, no memory access. Macro undefined: same request
//      -> normal 5-edge load, rsp_err=0.

Source files
------------

// File: rtl/mem_word_ctrl_pkg.sv
// Shared constants and FSM encoding for the word-to-byte memory controller.
package mem_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;
    localparam int WORD_W = NBYTES * BYTE_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_TAIL = 2'd3
    } state_e;

endpackage

// File: rtl/mem_word_ctrl_if.sv
// CPU request/response channel plus byte-memory port of the word controller.
interface mem_word_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_memwrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_data_in;
    logic [BYTE_W-1:0] mem_data_out;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_memwrite, mem_addr, mem_data_in
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_memwrite, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_word_ctrl.sv
// Splits 32-bit big-endian loads/stores into byte accesses on a 256x8 memory.
// Optional MEM_ALIGN_CHECK_EN rejects requests with req_addr[1:0] != 0.
module mem_word_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mem_word_ctrl_if.master bus
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0] mem_din_q, mem_din_d;
    logic              misalign;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (bus.req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    if (misalign) begin
                        state_d = RD_TAIL;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d      = 2'd1;
                        mem_addr_d = bus.req_addr;
                        if (bus.req_write) begin
                            state_d   = WR;
                            mem_we_d  = 1'b1;
                            mem_din_d = bus.req_wdata[WORD_W-1 -: BYTE_W];
                            shreg_d   = bus.req_wdata << BYTE_W;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            WR: begin
                // cnt wraps to 0 after the last byte has been issued
                if (cnt_q == 2'd0) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    mem_din_d  = shreg_q[WORD_W-1 -: BYTE_W];
                    shreg_d    = shreg_q << BYTE_W;
                    cnt_d      = cnt_q + 2'd1;
                end
            end
            RD: begin
                if (cnt_q == 2'd0) begin
                    state_d = RD_TAIL;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q + 2'd1;
                end
                // read data trails the issued address by two edges
                if (cnt_q != 2'd1) begin
                    shreg_d = {shreg_q[WORD_W-BYTE_W-1:0], bus.mem_data_out};
                end
            end
            RD_TAIL: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                if (err_q) begin
                    err_d       = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    rsp_rdata_d = {shreg_q[WORD_W-BYTE_W-1:0], bus.mem_data_out};
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.mem_memwrite = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_in  = mem_din_q;

endmodule
